// File: rtl/counter16_pkg.sv
// Shared definitions for the 16-bit up/down counter sequencer:
// host opcodes, sequencer states and per-byte terminal values.
package counter16_pkg;

  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_RUN   = 2'b01,
    OP_HALT  = 2'b10,
    OP_CLEAR = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LD_LO,
    S_LD_HI,
    S_RUN,
    S_DONE
  } state_e;

  localparam logic [7:0] BYTE_MAX = 8'hFF;
  localparam logic [7:0] BYTE_MIN = 8'h00;

endpackage

// File: rtl/counter16_term_det.sv
// Carry/borrow and 16-bit terminal-count detection for the cascaded
// byte counters; purely combinational.
module counter16_term_det
  import counter16_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic              updown,
  input  logic [BYTE_W-1:0] lo_byte,
  input  logic [BYTE_W-1:0] hi_byte,
  output logic              lo_term,
  output logic              full_term
);

  logic hi_term;

  // A byte is terminal at all-ones when counting up and all-zeros when down.
  assign lo_term   = updown ? (lo_byte == BYTE_MAX) : (lo_byte == BYTE_MIN);
  assign hi_term   = updown ? (hi_byte == BYTE_MAX) : (hi_byte == BYTE_MIN);
  assign full_term = lo_term && hi_term;

endmodule

// File: rtl/counter16_ctrl.sv
// Sequencer for a 16-bit counter built from two 8-bit units: serialises
// preloads onto the shared byte bus, cascades enables, applies wrap/stop.
module counter16_ctrl
  import counter16_pkg::*;
#(
  parameter int BYTE_W = 8,
  parameter int CNT_W  = 2 * BYTE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [CNT_W-1:0]  cmd_data,
  input  logic              cfg_updown,
  input  logic              cfg_wrapstop,
  input  logic [BYTE_W-1:0] lo_dcout,
  input  logic [BYTE_W-1:0] hi_dcout,
  output logic [BYTE_W-1:0] preld_val,
  output logic              lo_load,
  output logic              hi_load,
  output logic              lo_en,
  output logic              hi_en,
  output logic              updown,
  output logic              clr,
  output logic              busy,
  output logic              done,
  output logic              overflow
);

  state_e           state, state_nxt;
  op_e              op;
  logic [CNT_W-1:0] data_q;
  logic             updown_q;
  logic             wrapstop_q;
  logic             accept;
  logic             lo_term;
  logic             full_term;

  assign op = op_e'(cmd_op);

  counter16_term_det #(.BYTE_W(BYTE_W)) u_term_det (
    .updown    (updown_q),
    .lo_byte   (lo_dcout),
    .hi_byte   (hi_dcout),
    .lo_term   (lo_term),
    .full_term (full_term)
  );

  // In RUN only HALT may be accepted; anything else stalls the host.
  assign cmd_ready = (state == S_IDLE) || (state == S_DONE) ||
                     ((state == S_RUN) && (op == OP_HALT));
  assign accept    = cmd_valid && cmd_ready;

  assign updown = updown_q;
  assign busy   = (state != S_IDLE) && (state != S_DONE);
  assign done   = (state == S_DONE);

  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      data_q     <= '0;
      updown_q   <= 1'b1;
      wrapstop_q <= 1'b1;
    end else begin
      state <= state_nxt;
      if (accept && (op == OP_LOAD)) data_q <= cmd_data;
      if (accept && (op == OP_RUN)) begin
        updown_q   <= cfg_updown;
        wrapstop_q <= cfg_wrapstop;
      end
    end
  end

  // NOTE: every output of this block gets a default first so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    preld_val = '0;
    lo_load   = 1'b0;
    hi_load   = 1'b0;
    lo_en     = 1'b0;
    hi_en     = 1'b0;
    clr       = 1'b0;
    overflow  = 1'b0;
    unique case (state)
      S_IDLE, S_DONE: begin
        if (accept) begin
          unique case (op)
            OP_LOAD:  state_nxt = S_LD_LO;
            OP_RUN:   state_nxt = S_RUN;
            OP_HALT:  state_nxt = S_IDLE;
            OP_CLEAR: begin
              clr       = 1'b1;
              state_nxt = S_IDLE;
            end
          endcase
        end
      end
      S_LD_LO: begin
        preld_val = data_q[BYTE_W-1:0];
        lo_load   = 1'b1;
        state_nxt = S_LD_HI;
      end
      S_LD_HI: begin
        preld_val = data_q[CNT_W-1:BYTE_W];
        hi_load   = 1'b1;
        state_nxt = S_IDLE;
      end
      S_RUN: begin
        overflow = full_term;
        // HALT and stop-at-terminal both freeze the value in this cycle.
        if (accept) begin
          state_nxt = S_IDLE;
        end else if (full_term && !wrapstop_q) begin
          state_nxt = S_DONE;
        end else begin
          lo_en = 1'b1;
          hi_en = lo_term;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_counter16_ctrl.sv
// Bench for counter16_ctrl: two byte-counter units are modelled around the
// DUT; directed steps plus randomized runs against an arithmetic count model.
module tb_counter16_ctrl;
  import counter16_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op;
  logic [15:0] cmd_data;
  logic        cfg_updown;
  logic        cfg_wrapstop;
  logic [7:0]  lo_dcout;
  logic [7:0]  hi_dcout;
  logic [7:0]  preld_val;
  logic        lo_load;
  logic        hi_load;
  logic        lo_en;
  logic        hi_en;
  logic        updown;
  logic        clr;
  logic        busy;
  logic        done;
  logic        overflow;

  logic [7:0]  lo_q = 8'h00;
  logic [7:0]  hi_q = 8'h00;
  logic [15:0] cnt;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  counter16_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_data     (cmd_data),
    .cfg_updown   (cfg_updown),
    .cfg_wrapstop (cfg_wrapstop),
    .lo_dcout     (lo_dcout),
    .hi_dcout     (hi_dcout),
    .preld_val    (preld_val),
    .lo_load      (lo_load),
    .hi_load      (hi_load),
    .lo_en        (lo_en),
    .hi_en        (hi_en),
    .updown       (updown),
    .clr          (clr),
    .busy         (busy),
    .done         (done),
    .overflow     (overflow)
  );

  // The two 8-bit counter units the sequencer drives.
  always @(posedge clk) begin
    if (clr) begin
      lo_q <= 8'h00;
      hi_q <= 8'h00;
    end else begin
      if (lo_load)    lo_q <= preld_val;
      else if (lo_en) lo_q <= updown ? lo_q + 8'd1 : lo_q - 8'd1;
      if (hi_load)    hi_q <= preld_val;
      else if (hi_en) hi_q <= updown ? hi_q + 8'd1 : hi_q - 8'd1;
    end
  end

  assign lo_dcout = lo_q;
  assign hi_dcout = hi_q;
  assign cnt      = {hi_q, lo_q};

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic send(input op_e op, input logic [15:0] data, input logic ud, input logic ws);
    cmd_valid    = 1'b1;
    cmd_op       = op;
    cmd_data     = data;
    cfg_updown   = ud;
    cfg_wrapstop = ws;
    settle();
    check("send_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    settle();
  endtask

  task automatic load(input logic [15:0] v);
    send(OP_LOAD, v, 1'b0, 1'b0);
    tick();
    tick();
  endtask

  task automatic halt();
    cmd_valid = 1'b1;
    cmd_op    = OP_HALT;
    settle();
    check("halt_ready", cmd_ready, 1'b1);
    check("halt_lo_en", lo_en, 1'b0);
    check("halt_hi_en", hi_en, 1'b0);
    tick();
    cmd_valid = 1'b0;
    settle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] start, exp_v, term;
    logic        ud, ws, stopped;
    int          n;

    reset = 1'b1; cmd_valid = 1'b0; cmd_op = OP_HALT; cmd_data = '0;
    cfg_updown = 1'b1; cfg_wrapstop = 1'b1;
    tick(); tick();
    reset = 1'b0;
    settle();
    check("rst_busy",    busy, 1'b0);
    check("rst_done",    done, 1'b0);
    check("rst_ready",   cmd_ready, 1'b1);
    check("rst_updown",  updown, 1'b1);
    check("rst_preld",   preld_val, 8'h00);
    check("rst_strobes", {lo_load, hi_load, lo_en, hi_en, clr, overflow}, 6'b0);

    // Reset in the middle of a preload.
    send(OP_LOAD, 16'hABCD, 1'b0, 1'b0);
    check("ldlo_load",  lo_load, 1'b1);
    check("ldlo_preld", preld_val, 8'hCD);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("midrst_hi_load", hi_load, 1'b0);
    check("midrst_outs",    {lo_load, lo_en, hi_en, clr, overflow, busy, done}, 7'b0);
    check("midrst_preld",   preld_val, 8'h00);
    check("midrst_updown",  updown, 1'b1);
    check("midrst_ready",   cmd_ready, 1'b1);

    // Two-beat preload of 12FE.
    send(OP_LOAD, 16'h12FE, 1'b0, 1'b0);
    check("ld1_lo_load", lo_load, 1'b1);
    check("ld1_hi_load", hi_load, 1'b0);
    check("ld1_preld",   preld_val, 8'hFE);
    check("ld1_ready",   cmd_ready, 1'b0);
    tick();
    check("ld2_hi_load", hi_load, 1'b1);
    check("ld2_lo_load", lo_load, 1'b0);
    check("ld2_preld",   preld_val, 8'h12);
    tick();
    check("ld3_busy", busy, 1'b0);
    check("ld3_cnt",  cnt, 16'h12FE);

    // Up/wrap across the low-byte carry.
    send(OP_RUN, '0, 1'b1, 1'b1);
    check("carry0_lo_en", lo_en, 1'b1);
    check("carry0_hi_en", hi_en, 1'b0);
    cmd_valid = 1'b1;
    cmd_op    = OP_LOAD;
    settle();
    check("run_stall_ready", cmd_ready, 1'b0);
    cmd_valid = 1'b0;
    tick();
    check("carry1_cnt",   cnt, 16'h12FF);
    check("carry1_hi_en", hi_en, 1'b1);
    tick();
    check("carry2_cnt",   cnt, 16'h1300);
    check("carry2_hi_en", hi_en, 1'b0);
    halt();
    check("carry_halt_cnt", cnt, 16'h1300);

    // Up/wrap through FFFF.
    load(16'hFFFE);
    send(OP_RUN, '0, 1'b1, 1'b1);
    check("wrap0_ovf", overflow, 1'b0);
    tick();
    check("wrap1_cnt", cnt, 16'hFFFF);
    check("wrap1_ovf", overflow, 1'b1);
    check("wrap1_en",  {lo_en, hi_en}, 2'b11);
    tick();
    check("wrap2_cnt",  cnt, 16'h0000);
    check("wrap2_ovf",  overflow, 1'b0);
    check("wrap2_busy", busy, 1'b1);
    halt();

    // Down/stop at 0000, then re-run while already terminal.
    load(16'h0001);
    send(OP_RUN, '0, 1'b0, 1'b0);
    check("stop0_updown", updown, 1'b0);
    check("stop0_ovf",    overflow, 1'b0);
    tick();
    check("stop1_cnt",  cnt, 16'h0000);
    check("stop1_ovf",  overflow, 1'b1);
    check("stop1_en",   {lo_en, hi_en}, 2'b00);
    check("stop1_done", done, 1'b0);
    tick();
    check("stop2_done",  done, 1'b1);
    check("stop2_busy",  busy, 1'b0);
    check("stop2_ovf",   overflow, 1'b0);
    tick();
    check("stop3_cnt",  cnt, 16'h0000);
    check("stop3_done", done, 1'b1);
    send(OP_RUN, '0, 1'b0, 1'b0);
    check("term_run_ovf", overflow, 1'b1);
    check("term_run_en",  {lo_en, hi_en}, 2'b00);
    tick();
    check("term_run_done", done, 1'b1);
    check("term_run_cnt",  cnt, 16'h0000);
    halt();
    check("done_halt_done", done, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    settle();
    check("rst2_updown", updown, 1'b1);

    // HALT mid-run, then CLEAR.
    load(16'h0050);
    send(OP_RUN, '0, 1'b1, 1'b0);
    check("h50_lo_en", lo_en, 1'b1);
    halt();
    check("h50_busy", busy, 1'b0);
    check("h50_cnt",  cnt, 16'h0050);
    cmd_valid = 1'b1;
    cmd_op    = OP_CLEAR;
    settle();
    check("clr_pulse", clr, 1'b1);
    tick();
    cmd_valid = 1'b0;
    settle();
    check("clr_low", clr, 1'b0);
    check("clr_cnt", cnt, 16'h0000);

    // Randomized runs against an arithmetic model of the count.
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       start = 16'hFFFF - 16'($urandom_range(0, 20));
        1:       start = 16'($urandom_range(0, 20));
        default: start = 16'($urandom);
      endcase
      ud      = 1'($urandom_range(0, 1));
      ws      = 1'($urandom_range(0, 1));
      n       = $urandom_range(4, 40);
      term    = ud ? 16'hFFFF : 16'h0000;
      exp_v   = start;
      stopped = 1'b0;
      load(start);
      send(OP_RUN, '0, ud, ws);
      for (int c = 0; c < n; c++) begin
        check("rnd_cnt", cnt, exp_v);
        check("rnd_ovf", overflow, exp_v == term);
        if (!ws && (exp_v == term)) begin
          stopped = 1'b1;
          break;
        end
        exp_v = ud ? exp_v + 16'd1 : exp_v - 16'd1;
        tick();
      end
      if (stopped) begin
        tick();
        check("rnd_done", done, 1'b1);
        check("rnd_hold", cnt, exp_v);
        halt();
      end else begin
        check("rnd_pre_halt_cnt", cnt, exp_v);
        halt();
        check("rnd_halt_cnt",  cnt, exp_v);
        check("rnd_halt_busy", busy, 1'b0);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
